// File: rtl/parking_pool_scheduler.sv
// ---------------------------------------------------------------------------
// parking_pool_scheduler
//   Two-pool (university / free) parking occupancy tracker with an
//   hour-of-day capacity schedule. Applies one entry and one exit pulse per
//   cycle, exit first, and reports an accept/reject verdict for each entry.
//   Exits from an empty pool are ignored and flagged. A pool whose capacity
//   shrinks below its parked count is flagged over-occupied until enough
//   cars leave; cars are never evicted.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   car_entered / is_uni_car_entered   entry pulse and its pool qualifier
//   car_exited  / is_uni_car_exited    exit pulse and its pool qualifier
//   uni_parked_car, f_parked_car       registered per-pool parked counts
//   uni_vacated_space, f_vacated_space free spaces per pool, floored at 0
//   is_uni_vacated_space, is_vacated_space   non-zero vacancy flags
//   hour                           current hour 0..23
//   entry_ok, entry_rej, exit_err  one-cycle verdict pulses
//   uni_over, f_over               parked count exceeds current capacity
// ---------------------------------------------------------------------------
module parking_pool_scheduler #(
    parameter int CNT_W           = 10,
    parameter int TOTAL_CAP       = 700,
    parameter int UNI_CAP_DAY     = 500,
    parameter int UNI_CAP_NIGHT   = 200,
    parameter int DAY_START       = 8,
    parameter int RAMP_START      = 13,
    parameter int RAMP_STEP       = 50,
    parameter int CYCLES_PER_HOUR = 1000,
    parameter int START_HOUR      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_entered,
    input  logic             is_uni_car_entered,
    input  logic             car_exited,
    input  logic             is_uni_car_exited,
    output logic [CNT_W-1:0] uni_parked_car,
    output logic [CNT_W-1:0] f_parked_car,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic [CNT_W-1:0] f_vacated_space,
    output logic             is_uni_vacated_space,
    output logic             is_vacated_space,
    output logic [4:0]       hour,
    output logic             entry_ok,
    output logic             entry_rej,
    output logic             exit_err,
    output logic             uni_over,
    output logic             f_over
);

    localparam int CYC_W = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    logic [CYC_W-1:0] cyc_cnt;
    cnt_t             uni_cap;
    cnt_t             free_cap;
    int               hour_i;
    int               ramp_cap;

    assign hour_i = int'(hour);

    // Capacity schedule: flat day value, then a linear ramp-down that is
    // clamped at the night floor, and the night floor before the day starts.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    always_comb begin
        ramp_cap = UNI_CAP_DAY - (hour_i - RAMP_START + 1) * RAMP_STEP;
        uni_cap  = cnt_t'(UNI_CAP_NIGHT);
        if (hour_i >= RAMP_START) begin
            uni_cap = (ramp_cap > UNI_CAP_NIGHT) ? cnt_t'(ramp_cap) : cnt_t'(UNI_CAP_NIGHT);
        end else if (hour_i >= DAY_START) begin
            uni_cap = cnt_t'(UNI_CAP_DAY);
        end
        free_cap = cnt_t'(TOTAL_CAP) - uni_cap;
    end

    // Vacancy saturates at zero so a capacity shrink never wraps the display.
    assign uni_vacated_space    = (uni_parked_car < uni_cap)  ? uni_cap  - uni_parked_car : '0;
    assign f_vacated_space      = (f_parked_car   < free_cap) ? free_cap - f_parked_car   : '0;
    assign is_uni_vacated_space = (uni_vacated_space != '0);
    assign is_vacated_space     = (f_vacated_space   != '0);
    assign uni_over             = (uni_parked_car > uni_cap);
    assign f_over               = (f_parked_car   > free_cap);

    // Next-state arbitration: the exit is applied first, and the entry is
    // judged against the post-exit count, so a full pool can swap one car.
    cnt_t uni_post, f_post, uni_nxt, f_nxt;
    logic ok_nxt, rej_nxt, err_nxt;

    always_comb begin
        uni_post = uni_parked_car;
        f_post   = f_parked_car;
        err_nxt  = 1'b0;
        if (car_exited) begin
            if (is_uni_car_exited) begin
                if (uni_parked_car == '0) err_nxt  = 1'b1;
                else                      uni_post = uni_parked_car - cnt_t'(1);
            end else begin
                if (f_parked_car == '0)   err_nxt  = 1'b1;
                else                      f_post   = f_parked_car - cnt_t'(1);
            end
        end

        uni_nxt = uni_post;
        f_nxt   = f_post;
        ok_nxt  = 1'b0;
        rej_nxt = 1'b0;
        if (car_entered) begin
            if (is_uni_car_entered) begin
                if (uni_post < uni_cap) begin
                    uni_nxt = uni_post + cnt_t'(1);
                    ok_nxt  = 1'b1;
                end else begin
                    rej_nxt = 1'b1;
                end
            end else begin
                if (f_post < free_cap) begin
                    f_nxt  = f_post + cnt_t'(1);
                    ok_nxt = 1'b1;
                end else begin
                    rej_nxt = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register here is control state, so all of them are reset;
    // there is no storage array that could be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt        <= '0;
            hour           <= 5'(START_HOUR);
            uni_parked_car <= '0;
            f_parked_car   <= '0;
            entry_ok       <= 1'b0;
            entry_rej      <= 1'b0;
            exit_err       <= 1'b0;
        end else begin
            if (cyc_cnt == CYC_W'(CYCLES_PER_HOUR - 1)) begin
                cyc_cnt <= '0;
                hour    <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
            uni_parked_car <= uni_nxt;
            f_parked_car   <= f_nxt;
            entry_ok       <= ok_nxt;
            entry_rej      <= rej_nxt;
            exit_err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_parking_pool_scheduler.sv
// ---------------------------------------------------------------------------
// tb_parking_pool_scheduler
//   Scoreboard bench: each stimulus cycle updates a behavioural model (counts
//   plus an hour->capacity table) and queues the expected verdict; a separate
//   monitor pops and compares whenever the DUT responds.
// ---------------------------------------------------------------------------
module tb_parking_pool_scheduler;

    localparam int CNT_W      = 10;
    localparam int TOTAL_CAP  = 700;
    localparam int CPH        = 1000;
    localparam int START_HOUR = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic [CNT_W-1:0] uni_parked_car, f_parked_car, uni_vacated_space, f_vacated_space;
    logic             is_uni_vacated_space, is_vacated_space;
    logic [4:0]       hour;
    logic             entry_ok, entry_rej, exit_err, uni_over, f_over;

    parking_pool_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .car_entered         (car_entered),
        .is_uni_car_entered  (is_uni_car_entered),
        .car_exited          (car_exited),
        .is_uni_car_exited   (is_uni_car_exited),
        .uni_parked_car      (uni_parked_car),
        .f_parked_car        (f_parked_car),
        .uni_vacated_space   (uni_vacated_space),
        .f_vacated_space     (f_vacated_space),
        .is_uni_vacated_space(is_uni_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .hour                (hour),
        .entry_ok            (entry_ok),
        .entry_rej           (entry_rej),
        .exit_err            (exit_err),
        .uni_over            (uni_over),
        .f_over              (f_over)
    );

    always #5 clk = ~clk;

    // University capacity per hour for the default schedule.
    int uni_cap_tbl [24] = '{200, 200, 200, 200, 200, 200, 200, 200,
                             500, 500, 500, 500, 500, 450, 400, 350,
                             300, 250, 200, 200, 200, 200, 200, 200};

    typedef struct {
        bit ok;
        bit rej;
        bit err;
        int uni;
        int fr;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_ok_seen = 0;
    int n_rej_seen = 0;

    // Model state
    int m_uni, m_free, m_hour, m_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_levels(input string tag);
        int cap, fcap, uvac, fvac;
        cap  = uni_cap_tbl[m_hour];
        fcap = TOTAL_CAP - cap;
        uvac = (cap  > m_uni)  ? cap  - m_uni  : 0;
        fvac = (fcap > m_free) ? fcap - m_free : 0;
        check({tag, ".hour"},      hour,                 m_hour);
        check({tag, ".uni_cnt"},   uni_parked_car,       m_uni);
        check({tag, ".f_cnt"},     f_parked_car,         m_free);
        check({tag, ".uni_vac"},   uni_vacated_space,    uvac);
        check({tag, ".f_vac"},     f_vacated_space,      fvac);
        check({tag, ".is_uvac"},   is_uni_vacated_space, int'(uvac != 0));
        check({tag, ".is_fvac"},   is_vacated_space,     int'(fvac != 0));
        check({tag, ".uni_over"},  uni_over,             int'(m_uni > cap));
        check({tag, ".f_over"},    f_over,               int'(m_free > fcap));
    endtask

    // One clock cycle of stimulus; the model judges the events against the
    // hour the DUT holds before this edge, then advances model time.
    task automatic step(input bit ent, input bit ent_uni, input bit ex, input bit ex_uni);
        exp_t e;
        int   cap, fcap;
        @(negedge clk);
        car_entered        = ent;
        is_uni_car_entered = ent_uni;
        car_exited         = ex;
        is_uni_car_exited  = ex_uni;
        if (ent || ex) begin
            cap  = uni_cap_tbl[m_hour];
            fcap = TOTAL_CAP - cap;
            e.ok = 0; e.rej = 0; e.err = 0;
            if (ex) begin
                if (ex_uni) begin
                    if (m_uni == 0) e.err = 1; else m_uni--;
                end else begin
                    if (m_free == 0) e.err = 1; else m_free--;
                end
            end
            if (ent) begin
                if (ent_uni) begin
                    if (m_uni < cap) begin m_uni++; e.ok = 1; end else e.rej = 1;
                end else begin
                    if (m_free < fcap) begin m_free++; e.ok = 1; end else e.rej = 1;
                end
            end
            e.uni = m_uni;
            e.fr  = m_free;
            sb_q.push_back(e);
        end
        @(posedge clk);
        m_cyc++;
        if (m_cyc == CPH) begin
            m_cyc  = 0;
            m_hour = (m_hour + 1) % 24;
        end
        #1;
        car_entered = 1'b0; is_uni_car_entered = 1'b0;
        car_exited  = 1'b0; is_uni_car_exited  = 1'b0;
    endtask

    task automatic model_reset();
        m_uni = 0; m_free = 0; m_hour = START_HOUR; m_cyc = 0;
    endtask

    // Monitor: a response is due on the cycle after any sampled strobe.
    initial begin : monitor
        bit   due;
        exp_t e;
        forever begin
            @(posedge clk);
            due = car_entered | car_exited;
            #1;
            if (rst) continue;
            if (due || entry_ok || entry_rej || exit_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("verdict{ok,rej,err}", {entry_ok, entry_rej, exit_err}, {e.ok, e.rej, e.err});
                    check("uni_cnt_after_event", uni_parked_car, e.uni);
                    check("f_cnt_after_event",   f_parked_car,   e.fr);
                end
                n_ok_seen  += int'(entry_ok);
                n_rej_seen += int'(entry_rej);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  ok0, rej0, guard;
        bit  saw_wrap;
        int  prev_hour;

        rst = 1'b1;
        car_entered = 1'b0; is_uni_car_entered = 1'b0;
        car_exited  = 1'b0; is_uni_car_exited  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_levels("reset");
        check("reset.pulses", {entry_ok, entry_rej, exit_err}, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 202 free entries: 200 accepted, 2 rejected
        ok0 = n_ok_seen; rej0 = n_rej_seen;
        repeat (202) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("free_fill.ok_count",  n_ok_seen  - ok0,  200);
        check("free_fill.rej_count", n_rej_seen - rej0, 2);
        check_levels("free_fill");

        // Uni exit from an empty pool
        step(0, 0, 1, 1);
        check("empty_exit.exit_err", exit_err, 1);
        step(0, 0, 0, 0);
        check("empty_exit.clears", exit_err, 0);
        check_levels("empty_exit");

        // Fill uni to 500, then swap one car at full pool
        repeat (500) step(1, 1, 0, 0);
        check_levels("uni_full");
        step(1, 1, 1, 1);
        check("swap.entry_ok", entry_ok, 1);
        check("swap.uni_cnt",  uni_parked_car, 500);
        repeat (100) step(0, 0, 1, 1);
        check_levels("uni_400");

        // Run to hour 15 with 400 uni cars: over-occupied
        guard = 0;
        while (m_hour != 15 && guard < 20000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        check("reach_hour15", m_hour, 15);
        check_levels("hour15");
        step(1, 1, 0, 0);
        check("over.entry_rej", entry_rej, 1);
        repeat (51) step(0, 0, 1, 1);
        check("shrink.uni_349", uni_parked_car, 349);
        check_levels("shrink_done");

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)));
            if (i % 100 == 99) check_levels("random");
        end

        // A full day with one asynchronous reset mid-hour
        saw_wrap = 0;
        for (int i = 0; i < 24 * CPH; i++) begin
            if (i == 20 * CPH + CPH / 2) begin
                step(1, 1, 0, 0);
                #3 rst = 1'b1;
                #1;
                check("async_rst.uni_cnt", uni_parked_car, 0);
                check("async_rst.f_cnt",   f_parked_car,   0);
                check("async_rst.hour",    hour,           START_HOUR);
                check("async_rst.pulses",  {entry_ok, entry_rej, exit_err}, 0);
                model_reset();
                @(posedge clk);
                #2 rst = 1'b0;
                check_levels("after_rst");
            end else begin
                prev_hour = m_hour;
                step(bit'(i % 97 == 0), bit'($urandom_range(0, 1)),
                     bit'(i % 89 == 0), bit'($urandom_range(0, 1)));
                if (prev_hour == 23 && m_hour == 0) begin
                    saw_wrap = 1;
                    check_levels("hour_wrap");
                end
                if (m_cyc == 0) check("hourly.hour", hour, m_hour);
            end
        end
        check("saw_hour_wrap", int'(saw_wrap), 1);

        repeat (3) step(0, 0, 0, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
